pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 63 ++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with redirect priority, stall/halt control and fetch counting.
// Define PC_SEQ_REDIRECT_BUF_EN to buffer redirects that arrive while fetch is not advancing.
module pc_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_out,
  input  logic        ihit,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic [31:0] pc_next,
  output logic        pcWEN,
  output logic        flush,
  output logic        halted,
  output logic        redirect_pending,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic run, live, advance, pend;
  logic [31:0] live_tgt, pend_tgt;
  assign run = (state == RUN) && !RST;
  assign live = jr | jmp | br_taken;
  assign live_tgt = jr ? jr_target : jmp ? jmp_target : br_target;
  assign advance = run & ihit & ~stall & ~halt;
  assign pcWEN = advance;
  assign flush = advance & (pend | live);
  assign pc_next = !advance ? pc_out : pend ? pend_tgt : live ? live_tgt : pc_out + PC_STEP;
  assign halted = state == HALT;
  assign redirect_pending = pend;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= RUN;
      fetch_count <= '0;
    end else begin
      if (run && halt) state <= HALT;
      if (advance) fetch_count <= fetch_count + 32'd1;
    end
`ifdef PC_SEQ_REDIRECT_BUF_EN
  // Buffered redirect survives stalls; halt or the consuming advance clears it.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pend <= 1'b0;
      pend_tgt <= PC_INIT;
    end else if (run && (halt || advance)) begin
      pend <= 1'b0;
    end else if (run && live) begin
      pend <= 1'b1;
      pend_tgt <= live_tgt;
    end
`else
  assign pend = 1'b0;
  assign pend_tgt = PC_INIT;
`endif
endmodule
